// File: rtl/pipe_hazard_ctrl.sv
// Prioritised hazard controller beside the ID stage: load-use / branch-operand stalls,
// ID branch forwarding selects, flushes and dmem freezes. Optional counters: HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] IF_IDrs1,
  input  logic [REG_AW-1:0] IF_IDrs2,
  input  logic              IF_IDuseRs1,
  input  logic              IF_IDuseRs2,
  input  logic              IF_IDbranch,
  input  logic              branch_taken,
  input  logic [REG_AW-1:0] ID_EXrd,
  input  logic              ID_EXregWrite,
  input  logic              ID_EXmemRead,
  input  logic [REG_AW-1:0] EX_MEMrd,
  input  logic              EX_MEMregWrite,
  input  logic              EX_MEMmemRead,
  input  logic [REG_AW-1:0] MEM_WBrd,
  input  logic              MEM_WBregWrite,
  input  logic              ex_redirect,
  input  logic              dmem_wait,
  output logic              PCwrite,
  output logic              IF_IDwrite,
  output logic              IF_IDflush,
  output logic              ID_EXbubble,
  output logic              pipe_freeze,
  output logic [1:0]        br_rs1_sel,
  output logic [1:0]        br_rs2_sel
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL2 = 2'd1,
    STALL1 = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   stall;
  logic   ex_rs1, ex_rs2, mem_rs1, mem_rs2, wb_rs1, wb_rs2;
  logic   hz_lu, hz_ba, hz_bl, hz_bl2, hazard;

  function automatic logic hit(input logic [REG_AW-1:0] rd,
                               input logic [REG_AW-1:0] rs,
                               input logic              en);
    return en && (rd != '0) && (rd == rs);
  endfunction

  always_comb begin
    ex_rs1  = hit(ID_EXrd,  IF_IDrs1, IF_IDuseRs1);
    ex_rs2  = hit(ID_EXrd,  IF_IDrs2, IF_IDuseRs2);
    mem_rs1 = hit(EX_MEMrd, IF_IDrs1, IF_IDuseRs1);
    mem_rs2 = hit(EX_MEMrd, IF_IDrs2, IF_IDuseRs2);
    wb_rs1  = hit(MEM_WBrd, IF_IDrs1, IF_IDuseRs1);
    wb_rs2  = hit(MEM_WBrd, IF_IDrs2, IF_IDuseRs2);

    hz_lu  = ID_EXmemRead && (ex_rs1 || ex_rs2);
    hz_ba  = IF_IDbranch && ID_EXregWrite && !ID_EXmemRead && (ex_rs1 || ex_rs2);
    hz_bl  = IF_IDbranch && ID_EXmemRead && (ex_rs1 || ex_rs2);
    hz_bl2 = IF_IDbranch && EX_MEMmemRead && (mem_rs1 || mem_rs2);
    hazard = hz_lu || hz_ba || hz_bl || hz_bl2;
  end

  always_comb begin
    br_rs1_sel = 2'b00;
    br_rs2_sel = 2'b00;
    if (rst_n && IF_IDbranch) begin
      if (EX_MEMregWrite && !EX_MEMmemRead && mem_rs1) br_rs1_sel = 2'b01;
      else if (MEM_WBregWrite && wb_rs1)               br_rs1_sel = 2'b10;
      if (EX_MEMregWrite && !EX_MEMmemRead && mem_rs2) br_rs2_sel = 2'b01;
      else if (MEM_WBregWrite && wb_rs2)               br_rs2_sel = 2'b10;
    end
  end

  // Reset is folded in here so outputs take their reset values without waiting for a clock.
  always_comb begin
    state_nxt   = state;
    stall       = 1'b0;
    PCwrite     = 1'b1;
    IF_IDwrite  = 1'b1;
    IF_IDflush  = 1'b0;
    ID_EXbubble = 1'b0;
    pipe_freeze = 1'b0;
    if (!rst_n) begin
      state_nxt = RUN;
    end else if (dmem_wait) begin
      pipe_freeze = 1'b1;
      PCwrite     = 1'b0;
      IF_IDwrite  = 1'b0;
    end else if (ex_redirect) begin
      IF_IDflush  = 1'b1;
      ID_EXbubble = 1'b1;
      IF_IDwrite  = 1'b0;
      state_nxt   = RUN;
    end else begin
      unique case (state)
        STALL2: begin
          stall     = 1'b1;
          state_nxt = STALL1;
        end
        STALL1: begin
          stall     = 1'b1;
          state_nxt = RUN;
        end
        default: begin
          if (hazard) begin
            stall     = 1'b1;
            state_nxt = hz_bl ? STALL1 : RUN;
          end else if (IF_IDbranch && branch_taken) begin
            IF_IDflush = 1'b1;
            IF_IDwrite = 1'b0;
          end
        end
      endcase
      if (stall) begin
        PCwrite     = 1'b0;
        IF_IDwrite  = 1'b0;
        ID_EXbubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall)      stall_cnt <= stall_cnt + 32'd1;
      if (IF_IDflush) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard sequences then random traffic,
// checked against a stall-budget reference model.
module tb_pipe_hazard_ctrl;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] IF_IDrs1, IF_IDrs2, ID_EXrd, EX_MEMrd, MEM_WBrd;
  logic          IF_IDuseRs1, IF_IDuseRs2, IF_IDbranch, branch_taken;
  logic          ID_EXregWrite, ID_EXmemRead, EX_MEMregWrite, EX_MEMmemRead, MEM_WBregWrite;
  logic          ex_redirect, dmem_wait;
  logic          PCwrite, IF_IDwrite, IF_IDflush, ID_EXbubble, pipe_freeze;
  logic [1:0]    br_rs1_sel, br_rs2_sel;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0]   stall_cnt, flush_cnt;
`endif

  pipe_hazard_ctrl #(.REG_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .IF_IDrs1(IF_IDrs1), .IF_IDrs2(IF_IDrs2),
    .IF_IDuseRs1(IF_IDuseRs1), .IF_IDuseRs2(IF_IDuseRs2),
    .IF_IDbranch(IF_IDbranch), .branch_taken(branch_taken),
    .ID_EXrd(ID_EXrd), .ID_EXregWrite(ID_EXregWrite), .ID_EXmemRead(ID_EXmemRead),
    .EX_MEMrd(EX_MEMrd), .EX_MEMregWrite(EX_MEMregWrite), .EX_MEMmemRead(EX_MEMmemRead),
    .MEM_WBrd(MEM_WBrd), .MEM_WBregWrite(MEM_WBregWrite),
    .ex_redirect(ex_redirect), .dmem_wait(dmem_wait),
    .PCwrite(PCwrite), .IF_IDwrite(IF_IDwrite), .IF_IDflush(IF_IDflush),
    .ID_EXbubble(ID_EXbubble), .pipe_freeze(pipe_freeze),
    .br_rs1_sel(br_rs1_sel), .br_rs2_sel(br_rs2_sel)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc;
    logic       ifw;
    logic       fl;
    logic       bub;
    logic       frz;
    logic [1:0] s1;
    logic [1:0] s2;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] sc;
    logic [31:0] fc;
`endif
  } out_t;

  out_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: the number of further stall cycles already owed, plus event counts.
  int          owed = 0;
  logic [31:0] m_stalls = '0;
  logic [31:0] m_flush = '0;

  function automatic logic reads(input logic [AW-1:0] r);
    return (r != 0) && ((IF_IDuseRs1 && IF_IDrs1 == r) || (IF_IDuseRs2 && IF_IDrs2 == r));
  endfunction

  function automatic int stalls_needed();
    int n = 0;
    if (ID_EXmemRead && reads(ID_EXrd)) n = IF_IDbranch ? 2 : 1;
    if (IF_IDbranch && ID_EXregWrite && !ID_EXmemRead && reads(ID_EXrd) && n < 1) n = 1;
    if (IF_IDbranch && EX_MEMmemRead && reads(EX_MEMrd) && n < 1) n = 1;
    return n;
  endfunction

  function automatic logic [1:0] src_of(input logic [AW-1:0] rs, input logic en);
    if (!en || rs == 0 || !IF_IDbranch) return 2'b00;
    if (EX_MEMregWrite && !EX_MEMmemRead && EX_MEMrd == rs) return 2'b01;
    if (MEM_WBregWrite && MEM_WBrd == rs) return 2'b10;
    return 2'b00;
  endfunction

  task automatic issue();
    out_t e;
    int   need;
    e = '0;
    if (!rst_n) begin
      owed = 0; m_stalls = '0; m_flush = '0;
    end
`ifdef HAZ_PERF_CNT_EN
    e.sc = m_stalls;
    e.fc = m_flush;
`endif
    if (!rst_n) begin
      e.pc = 1; e.ifw = 1;
    end else begin
      e.s1 = src_of(IF_IDrs1, IF_IDuseRs1);
      e.s2 = src_of(IF_IDrs2, IF_IDuseRs2);
      need = stalls_needed();
      if (dmem_wait) begin
        e.frz = 1;
      end else if (ex_redirect) begin
        e.pc = 1; e.fl = 1; e.bub = 1; owed = 0; m_flush++;
      end else if (owed > 0) begin
        e.bub = 1; owed--; m_stalls++;
      end else if (need > 0) begin
        e.bub = 1; owed = need - 1; m_stalls++;
      end else if (IF_IDbranch && branch_taken) begin
        e.pc = 1; e.fl = 1; m_flush++;
      end else begin
        e.pc = 1; e.ifw = 1;
      end
    end
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    out_t e, a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = '0;
      a.pc = PCwrite; a.ifw = IF_IDwrite; a.fl = IF_IDflush; a.bub = ID_EXbubble;
      a.frz = pipe_freeze; a.s1 = br_rs1_sel; a.s2 = br_rs2_sel;
`ifdef HAZ_PERF_CNT_EN
      a.sc = stall_cnt; a.fc = flush_cnt;
`endif
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs @%0t: got %h required %h (pc,ifw,fl,bub,frz,s1,s2[,cnts])",
                 $time, a, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    IF_IDrs1 = '0; IF_IDrs2 = '0; IF_IDuseRs1 = 0; IF_IDuseRs2 = 0;
    IF_IDbranch = 0; branch_taken = 0;
    ID_EXrd = '0; ID_EXregWrite = 0; ID_EXmemRead = 0;
    EX_MEMrd = '0; EX_MEMregWrite = 0; EX_MEMmemRead = 0;
    MEM_WBrd = '0; MEM_WBregWrite = 0;
    ex_redirect = 0; dmem_wait = 0;
  endtask

  task automatic load_branch();
    nop();
    IF_IDbranch = 1; IF_IDrs1 = 5'd0; IF_IDuseRs1 = 1; IF_IDrs2 = 5'd5; IF_IDuseRs2 = 1;
    ID_EXrd = 5'd5; ID_EXregWrite = 1; ID_EXmemRead = 1;
  endtask

  initial begin
    int wait_cycles;
    nop();
    rst_n = 0;
    tick(); issue();
    tick(); rst_n = 1; nop(); issue();

    // lw x5 in EX, add x6,x5,x7 in ID
    tick(); nop(); ID_EXrd = 5'd5; ID_EXregWrite = 1; ID_EXmemRead = 1;
    IF_IDrs1 = 5'd5; IF_IDuseRs1 = 1; IF_IDrs2 = 5'd7; IF_IDuseRs2 = 1; issue();
    tick(); nop(); issue();

    // add x5 in EX, beq x5,x0 taken
    tick(); nop(); IF_IDbranch = 1; branch_taken = 1; IF_IDrs1 = 5'd5; IF_IDuseRs1 = 1;
    IF_IDuseRs2 = 1; ID_EXrd = 5'd5; ID_EXregWrite = 1; issue();
    tick(); ID_EXrd = '0; ID_EXregWrite = 0; EX_MEMrd = 5'd5; EX_MEMregWrite = 1; issue();
    tick(); nop(); issue();

    // lw x5 in EX, beq x0,x5
    tick(); load_branch(); issue();
    tick(); ID_EXrd = '0; ID_EXregWrite = 0; ID_EXmemRead = 0;
    EX_MEMrd = 5'd5; EX_MEMregWrite = 1; EX_MEMmemRead = 1; issue();
    tick(); EX_MEMrd = '0; EX_MEMregWrite = 0; EX_MEMmemRead = 0;
    MEM_WBrd = 5'd5; MEM_WBregWrite = 1; issue();

    // lw x0 in EX, add x1,x0,x0
    tick(); nop(); ID_EXrd = '0; ID_EXregWrite = 1; ID_EXmemRead = 1;
    IF_IDuseRs1 = 1; IF_IDuseRs2 = 1; issue();

    // dmem_wait held for 3 cycles inside STALL1
    tick(); load_branch(); issue();
    tick(); nop(); dmem_wait = 1; issue();
    tick(); issue();
    tick(); issue();
    tick(); dmem_wait = 0; issue();
    tick(); issue();

    // ex_redirect inside STALL1
    tick(); load_branch(); issue();
    tick(); nop(); ex_redirect = 1; issue();
    tick(); ex_redirect = 0; issue();

    // async reset mid-stall
    tick(); load_branch(); issue();
    tick(); nop(); IF_IDbranch = 1; branch_taken = 1; rst_n = 0; issue();
    tick(); rst_n = 1; issue();
    tick(); nop(); issue();

    for (int i = 0; i < 2000; i++) begin
      tick();
      IF_IDrs1       = AW'($urandom_range(0, 3));
      IF_IDrs2       = AW'($urandom_range(0, 3));
      IF_IDuseRs1    = 1'($urandom_range(0, 3) != 0);
      IF_IDuseRs2    = 1'($urandom_range(0, 3) != 0);
      IF_IDbranch    = 1'($urandom_range(0, 1));
      branch_taken   = 1'($urandom_range(0, 1));
      ID_EXrd        = AW'($urandom_range(0, 3));
      ID_EXregWrite  = 1'($urandom_range(0, 1));
      ID_EXmemRead   = 1'($urandom_range(0, 2) == 0);
      EX_MEMrd       = AW'($urandom_range(0, 3));
      EX_MEMregWrite = 1'($urandom_range(0, 1));
      EX_MEMmemRead  = 1'($urandom_range(0, 2) == 0);
      MEM_WBrd       = AW'($urandom_range(0, 3));
      MEM_WBregWrite = 1'($urandom_range(0, 1));
      ex_redirect    = 1'($urandom_range(0, 19) == 0);
      dmem_wait      = 1'($urandom_range(0, 9) == 0);
      rst_n          = 1'($urandom_range(0, 99) != 0);
      issue();
    end
    tick(); rst_n = 1; nop(); issue();

    wait_cycles = 0;
    while (exp_q.size() != 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Sequential hazard controller for the 5-stage RISC-V pipeline, sitting beside the ID stage. It sequences load-use stalls, branch-operand stalls (branches resolve in ID), ID-stage branch forwarding selects, taken-branch and EX-redirect flushes, and data-memory wait freezes. It replaces ad-hoc per-hazard stall logic with one prioritised FSM that enforces multi-cycle stall sequences.

## Interface
Parameters:
- `REG_AW`, 5, register address width.

Ports. One clock; reset is asynchronous and active-low.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: async active-low reset.
- `IF_IDrs1`, `IF_IDrs2` in REG_AW: source registers of the instruction in ID.
- `IF_IDuseRs1`, `IF_IDuseRs2` in 1: the instruction in ID actually reads rs1/rs2.
- `IF_IDbranch` in 1: the instruction in ID is a conditional branch.
- `branch_taken` in 1: ID comparator result, valid only when the operands are forwarded correctly.
- `ID_EXrd` in REG_AW, `ID_EXregWrite` in 1, `ID_EXmemRead` in 1: the EX-stage producer.
- `EX_MEMrd` in REG_AW, `EX_MEMregWrite` in 1, `EX_MEMmemRead` in 1: the MEM-stage producer.
- `MEM_WBrd` in REG_AW, `MEM_WBregWrite` in 1: the WB-stage producer.
- `ex_redirect` in 1: a jalr or mispredict resolved in EX.
- `dmem_wait` in 1: data memory is not ready.
- `PCwrite` out 1: PC load enable.
- `IF_IDwrite` out 1: IF/ID load enable.
- `IF_IDflush` out 1: zero IF/ID on the next edge.
- `ID_EXbubble` out 1: zero ID/EX control bits (regWrite, memWrite, memRead, branch) on the next edge.
- `pipe_freeze` out 1: hold every pipeline register.
- `br_rs1_sel`, `br_rs2_sel` out 2: ID branch operand source. 00 = regfile, 01 = EX/MEM ALU result, 10 = MEM/WB write data.

## Operation
- A register match requires a nonzero rd, an rd equal to the source register, and the corresponding `use` bit set. x0 never matches.
- Hazard terms, evaluated in RUN:
  - H_LU: `ID_EXmemRead` and a match on rs1 or rs2. Non-branch case, needs 1 stall.
  - H_BA: `IF_IDbranch`, `ID_EXregWrite`, `!ID_EXmemRead`, and a match. Needs 1 stall.
  - H_BL: `IF_IDbranch`, `ID_EXmemRead`, and a match. Needs 2 stalls.
  - H_BL2: `IF_IDbranch`, `EX_MEMmemRead`, and a match against `EX_MEMrd`. Needs 1 stall.
- Branch operand select, per operand:
  - 01 if `EX_MEMregWrite`, `!EX_MEMmemRead`, and a match.
  - Otherwise 10 if `MEM_WBregWrite` and a match.
  - Otherwise 00.
  - Outputs 00 when `IF_IDbranch` = 0.
- FSM states: RUN, STALL2, STALL1.
  - RUN, with a hazard detected:
    - Stall this cycle: `PCwrite`=0, `IF_IDwrite`=0, `ID_EXbubble`=1.
    - Next state is STALL1 if H_BL, otherwise RUN. The H_BL chain is RUN → STALL1 → RUN.
  - STALL2 is reserved for a 3-cycle memory-latency option. It always moves to STALL1 and is unreachable in this revision.
  - STALL1: stall unconditionally (Moore behaviour), without re-deriving hazards, then go to RUN.
- Priority, highest first:
  1. `dmem_wait`: `pipe_freeze`=1, `PCwrite`=0, `IF_IDwrite`=0, no bubble, no flush. State and counters hold.
  2. `ex_redirect`: `IF_IDflush`=1, `ID_EXbubble`=1, `PCwrite`=1. State is forced to RUN, aborting any stall sequence.
  3. A hazard stall, as above.
  4. `IF_IDbranch` with `branch_taken` and no hazard this cycle: `IF_IDflush`=1, `PCwrite`=1.
  5. Otherwise: `PCwrite`=1, `IF_IDwrite`=1, all other outputs 0.
- `branch_taken` is ignored in any cycle that stalls.

## Timing
- Reset (`rst_n` low, asynchronous):
  - State is RUN and counters are 0.
  - Outputs are forced to `PCwrite`=1, `IF_IDwrite`=1, all other outputs 0, regardless of the other inputs.
- Hazard outputs in RUN are combinational, producing a stall in the same cycle the hazard is present.
- STALL1 outputs are decoded from registered state.
- Stall length:
  - Load-use: 1 cycle.
  - ALU→branch: 1 cycle, then select 01.
  - Load→branch: 2 cycles, then select 10.
  - Load two instructions ahead → branch: 1 cycle, then select 10.
- `dmem_wait` arriving during STALL1 extends the stall. STALL1 is left only on the first edge with `dmem_wait`=0.
- A taken branch flushes exactly one IF/ID slot.

## Configuration
- `HAZ_PERF_CNT_EN` defined:
  - Adds outputs `stall_cnt` and `flush_cnt`, each 32 bits, reset to 0.
  - `stall_cnt` increments on every hazard-stall cycle.
  - `flush_cnt` increments on every cycle with `IF_IDflush`=1.
  - Both hold during `dmem_wait` and wrap from 0xFFFFFFFF to 0.
- Not defined: these ports and counters are absent. All other behaviour is identical.

## Test plan
- `lw x5` in EX, `add x6,x5,x7` in ID: exactly 1 cycle with `PCwrite`=0 and `ID_EXbubble`=1, then normal flow.
- `add x5` in EX, `beq x5,x0` in ID: 1 stall, then `br_rs1_sel`=01 and a taken branch gives `IF_IDflush`=1 for 1 cycle.
- `lw x5` in EX, `beq x0,x5` in ID: 2 stall cycles (RUN → STALL1 → RUN), then `br_rs2_sel`=10.
- `lw x0` in EX, `add x1,x0,x0` in ID: no stall. rd=0 never matches.
- In STALL1, assert `dmem_wait` for 3 cycles: `pipe_freeze`=1 for all 3, then 1 stall cycle, then RUN.
- `ex_redirect` in STALL1: same-cycle `IF_IDflush`=1 and `ID_EXbubble`=1, next state RUN. Assert `rst_n`=0 mid-stall: outputs return to reset values immediately.
